mk_key_loader: RTL and testbench

- Writable master-key source for the crypto core, loaded over a byte-wide valid/ready stream.
- Drives the same 128-bit master-key bus that the fixed ROM key drives.
- Holds the package default master key until a full 16-byte key is committed.
- Supports clear-to-default and aborts a load on inter-byte timeout.

---
 rtl/mk_key_pkg.sv | 16 +
 rtl/flex_timeout_counter.sv | 28 ++
 rtl/mk_key_loader.sv | 121 ++++++++++++
 tb/tb_mk_key_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mk_key_pkg.sv
// Shared master-key constants and loader state type; DEFAULT_MK is also the ROM key.
package mk_key_pkg;

  localparam int unsigned KEY_W     = 128;
  localparam int unsigned KEY_BYTES = 16;
  localparam int unsigned CNT_W     = 5;

  localparam logic [KEY_W-1:0] DEFAULT_MK = 128'h6265657062656570606574747563652e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

endpackage

// File: rtl/flex_timeout_counter.sv
// Idle-cycle counter that saturates at ROLLOVER and flags while it sits there.
module flex_timeout_counter #(
  parameter int unsigned ROLLOVER = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic count_enable,
  output logic rollover_flag
);

  localparam int unsigned CW = $clog2(ROLLOVER + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable && (count != CW'(ROLLOVER))) begin
      count <= count + CW'(1);
    end
  end

  assign rollover_flag = (count == CW'(ROLLOVER));

endmodule

// File: rtl/mk_key_loader.sv
// Byte-stream loaded master key; holds DEFAULT_MK until a complete 16-byte key commits.
module mk_key_loader
  import mk_key_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             key_clear,
  output logic [KEY_W-1:0] mk_key,
  output logic             key_src,
  output logic             key_busy,
  output logic             key_update,
  output logic             load_err
);

  state_t             state, state_d;
  logic [KEY_W-1:0]   stage, stage_d;
  logic [KEY_W-1:0]   mk_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               src_d, upd_d, err_d, ready_d;
  logic               accept;
  logic               tmo_en, tmo_clear, tmo_flag;

  flex_timeout_counter #(
    .ROLLOVER(TIMEOUT_CYC)
  ) u_tmo (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (tmo_clear),
    .count_enable (tmo_en),
    .rollover_flag(tmo_flag)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      stage      <= '0;
      cnt        <= '0;
      mk_key     <= DEFAULT_MK;
      key_src    <= 1'b0;
      key_update <= 1'b0;
      load_err   <= 1'b0;
      byte_ready <= 1'b0;
    end else begin
      state      <= state_d;
      stage      <= stage_d;
      cnt        <= cnt_d;
      mk_key     <= mk_d;
      key_src    <= src_d;
      key_update <= upd_d;
      load_err   <= err_d;
      byte_ready <= ready_d;
    end
  end

  always_comb begin
    accept    = byte_valid && byte_ready;
    state_d   = state;
    stage_d   = stage;
    cnt_d     = cnt;
    mk_d      = mk_key;
    src_d     = key_src;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    key_busy  = (state != IDLE);
    tmo_en    = (state == LOAD) && !accept;
    tmo_clear = key_clear || accept || tmo_flag || (state != LOAD);

    case (state)
      IDLE: begin
        if (accept) begin
          stage_d = {stage[KEY_W-9:0], byte_in};
          cnt_d   = CNT_W'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        // An accept on the expiry cycle wins over the timeout.
        if (accept) begin
          stage_d = {stage[KEY_W-9:0], byte_in};
          cnt_d   = cnt + CNT_W'(1);
          if (cnt_d == CNT_W'(KEY_BYTES)) begin
            state_d = COMMIT;
          end
        end else if (tmo_flag) begin
          stage_d = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        mk_d    = stage;
        src_d   = 1'b1;
        upd_d   = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (key_clear) begin
      state_d = IDLE;
      stage_d = '0;
      cnt_d   = '0;
      mk_d    = DEFAULT_MK;
      src_d   = 1'b0;
      upd_d   = 1'b0;
      err_d   = 1'b0;
    end

    ready_d = (state_d != COMMIT);
  end

endmodule

// File: tb/tb_mk_key_loader.sv
// Bench for mk_key_loader: table-driven key loads, hand-written corner sequences, random gapped loads.
module tb_mk_key_loader;

  localparam int TMO = 8;
  localparam logic [127:0] DEF_MK = 128'h6265657062656570606574747563652e;

  logic         clk;
  logic         n_rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         key_clear;
  logic [127:0] mk_key;
  logic         key_src;
  logic         key_busy;
  logic         key_update;
  logic         load_err;

  mk_key_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .key_clear (key_clear),
    .mk_key    (mk_key),
    .key_src   (key_src),
    .key_busy  (key_busy),
    .key_update(key_update),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  int inv_bad = 0;

  logic [127:0] exp_q[$];
  logic [127:0] model_key = DEF_MK;
  logic         clr_pend = 1'b0;

  typedef struct {
    logic [7:0]   start;
    logic [7:0]   step;
    logic [127:0] key;
  } vec_t;

  function automatic void chk_k(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  function automatic void chk_b(input string name, input logic got, input logic exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endfunction

  function automatic void chk_i(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endfunction

  // Reference: mk_key only moves at reset, one edge after a clear, or on a key_update
  // that presents the oldest fully-sent key.
  always @(negedge clk) begin
    if (!n_rst) begin
      model_key = DEF_MK;
      clr_pend  = 1'b0;
    end else begin
      if (clr_pend) model_key = DEF_MK;
      if (key_update) begin
        upd_cnt++;
        if (exp_q.size() == 0) chk_b("key_update with no pending key", key_update, 1'b0);
        else begin
          model_key = exp_q.pop_front();
          chk_k("committed key value", mk_key, model_key);
        end
      end
      if (mk_key !== model_key) inv_bad++;
      if (load_err) err_cnt++;
      clr_pend = key_clear;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int stalls);
    int w;
    w = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && w < 40) begin
      tick();
      w++;
    end
    if (!byte_ready) chk_b("byte_ready wait bound", byte_ready, 1'b1);
    tick();
    stalls = w;
  endtask

  task automatic load_timed(input vec_t v);
    logic [127:0] prior;
    logic [7:0]   b;
    int           st, st_tot;
    prior  = model_key;
    st_tot = 0;
    exp_q.push_back(v.key);
    for (int i = 0; i < 16; i++) begin
      b = v.start + v.step * 8'(i);
      send_byte(b, st);
      st_tot += st;
    end
    byte_valid = 1'b0;
    chk_i("byte_ready stalls during load", st_tot, 0);
    chk_b("byte_ready low in commit", byte_ready, 1'b0);
    chk_b("key_busy in commit", key_busy, 1'b1);
    chk_k("mk_key unchanged before commit", mk_key, prior);
    tick();
    chk_b("key_update pulse", key_update, 1'b1);
    chk_k("mk_key after commit", mk_key, v.key);
    chk_b("key_src after commit", key_src, 1'b1);
    chk_b("byte_ready after commit", byte_ready, 1'b1);
    chk_b("key_busy after commit", key_busy, 1'b0);
    tick();
    chk_b("key_update one cycle", key_update, 1'b0);
  endtask

  initial begin
    vec_t         vecs[4];
    int           st, u0, e0;
    logic [127:0] rk;
    logic [7:0]   b;

    vecs[0] = '{8'h00, 8'h01, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{8'h10, 8'h11, 128'h102132435465768798a9bacbdcedfe0f};
    vecs[2] = '{8'h80, 8'hff, 128'h807f7e7d7c7b7a797877767574737271};
    vecs[3] = '{8'hff, 8'h00, 128'hffffffffffffffffffffffffffffffff};

    n_rst = 1'b0; byte_in = '0; byte_valid = 1'b0; key_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_b("byte_ready in reset", byte_ready, 1'b0);
    chk_k("mk_key in reset", mk_key, DEF_MK);
    chk_b("key_update in reset", key_update, 1'b0);
    chk_b("load_err in reset", load_err, 1'b0);
    n_rst = 1'b1;
    repeat (3) tick();
    chk_k("mk_key after reset", mk_key, DEF_MK);
    chk_b("key_src after reset", key_src, 1'b0);
    chk_b("byte_ready after reset", byte_ready, 1'b1);
    chk_b("key_busy after reset", key_busy, 1'b0);

    for (int k = 0; k < 4; k++) load_timed(vecs[k]);

    // Single-cycle clear after the all-ones key.
    u0 = upd_cnt;
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    chk_k("mk_key after clear", mk_key, DEF_MK);
    chk_b("key_src after clear", key_src, 1'b0);
    chk_b("key_update after clear", key_update, 1'b0);
    tick();
    chk_i("no update from clear", upd_cnt, u0);

    // Load a key but clear during its commit cycle.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), st);
    byte_valid = 1'b0;
    chk_b("byte_ready low before clear-commit", byte_ready, 1'b0);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    chk_k("mk_key clear-on-commit", mk_key, DEF_MK);
    chk_b("key_src clear-on-commit", key_src, 1'b0);
    chk_b("key_update clear-on-commit", key_update, 1'b0);
    repeat (2) tick();
    chk_i("no update after clear-on-commit", upd_cnt, u0);

    // Clear mid-load with a byte offered in the clear cycle: nothing carries over.
    for (int i = 0; i < 7; i++) send_byte(8'h5a, st);
    byte_in = 8'haa; byte_valid = 1'b1; key_clear = 1'b1;
    tick();
    key_clear = 1'b0; byte_valid = 1'b0;
    chk_b("key_busy after mid-load clear", key_busy, 1'b0);
    load_timed(vecs[2]);

    // Timeout abort after 5 bytes.
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'h33, st);
    byte_valid = 1'b0;
    repeat (TMO) tick();
    chk_b("load_err before expiry", load_err, 1'b0);
    chk_b("key_busy before expiry", key_busy, 1'b1);
    tick();
    chk_b("load_err pulse", load_err, 1'b1);
    chk_b("key_busy after abort", key_busy, 1'b0);
    chk_k("mk_key kept after abort", mk_key, vecs[2].key);
    chk_b("key_src kept after abort", key_src, 1'b1);
    tick();
    chk_b("load_err one cycle", load_err, 1'b0);
    chk_i("load_err pulse count", err_cnt - e0, 1);
    load_timed(vecs[0]);

    // Accept on the expiry cycle beats the timeout.
    e0 = err_cnt;
    exp_q.push_back(128'h404346494c4f5255585b5e6164676a6d);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        byte_valid = 1'b0;
        repeat (TMO) tick();
      end
      send_byte(8'(8'h40 + 3 * i), st);
    end
    byte_valid = 1'b0;
    tick();
    chk_b("key_update after late byte", key_update, 1'b1);
    chk_k("mk_key after late byte", mk_key, 128'h404346494c4f5255585b5e6164676a6d);
    tick();
    chk_i("no load_err when accept wins", err_cnt - e0, 0);

    // Asynchronous reset mid-load.
    for (int i = 0; i < 10; i++) send_byte(8'h77, st);
    byte_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk_k("mk_key async reset", mk_key, DEF_MK);
    chk_b("key_src async reset", key_src, 1'b0);
    chk_b("byte_ready async reset", byte_ready, 1'b0);
    chk_b("key_busy async reset", key_busy, 1'b0);
    tick();
    n_rst = 1'b1;
    repeat (2) tick();
    load_timed(vecs[1]);

    // Random gaps below the timeout over three back-to-back keys.
    u0 = upd_cnt;
    e0 = err_cnt;
    rk = '0;
    for (int k = 0; k < 3; k++) begin
      rk = '0;
      for (int i = 0; i < 16; i++) begin
        b  = 8'($urandom);
        rk = {rk[119:0], b};
      end
      exp_q.push_back(rk);
      for (int i = 0; i < 16; i++) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(TMO - 1, 0)) tick();
        send_byte(rk[127 - 8 * i -: 8], st);
      end
    end
    byte_valid = 1'b0;
    repeat (4) tick();
    chk_i("random key_update count", upd_cnt - u0, 3);
    chk_i("random load_err count", err_cnt - e0, 0);
    chk_i("pending keys left", exp_q.size(), 0);
    chk_k("mk_key last random key", mk_key, rk);

    chk_i("mk_key invariant violations", inv_bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
